// File: rtl/fifo_arb_ctrl.sv
// Two-requester write arbiter and FIFO pointer controller for an external
// dual-port RAM with synchronous, one-cycle-latency reads.
module fifo_arb_ctrl #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          req0,
  input  logic [DW-1:0] din0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [DW-1:0] din1,
  output logic          gnt1,
  input  logic          rd_req,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          rr;
  logic          wr_ok;
  logic          wr_en;
  logic          rd_fire;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);

  // rr low favours requester 0 when both ask in the same cycle.
  assign wr_ok = !rst && !full && !flush;
  assign gnt0  = wr_ok && req0 && (!req1 || !rr);
  assign gnt1  = wr_ok && req1 && (!req0 || rr);
  assign wr_en = gnt0 || gnt1;

  assign ram_we    = wr_en;
  assign ram_waddr = wptr;
  assign ram_wdata = gnt1 ? din1 : din0;

  assign rd_fire   = rd_req && !empty && !flush;
  assign ram_raddr = rptr;
  assign rd_data   = ram_rdata;

  // Pointers count downward from the top address and wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '1;
      rptr     <= '1;
      count    <= '0;
      rr       <= 1'b0;
      rd_valid <= 1'b0;
    end else if (flush) begin
      wptr     <= '1;
      rptr     <= '1;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (wr_en) begin
        wptr <= wptr - 1'b1;
        rr   <= gnt0;
      end
      if (rd_fire) begin
        rptr <= rptr - 1'b1;
      end
      case ({wr_en, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Randomized and directed bench for fifo_arb_ctrl; a queue-based FIFO model and
// a RAM array live here, and every cycle the DUT is compared against the model.
module tb_fifo_arb_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          req0;
  logic [DW-1:0] din0;
  logic          gnt0;
  logic          req1;
  logic [DW-1:0] din1;
  logic          gnt1;
  logic          rd_req;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic          full;
  logic          empty;
  logic [AW:0]   count;

  fifo_arb_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0(req0), .din0(din0), .gnt0(gnt0),
    .req1(req1), .din1(din1), .gnt1(gnt1),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  // Behavioural dual-port RAM: write port A, registered read port B.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  // Reference model state: stored entries in order plus arbitration history.
  logic [DW-1:0] q[$];
  bit            m_rr;
  int            wr_idx;
  int            rd_idx;
  bit            m_valid;
  logic [DW-1:0] m_data;

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit f, input bit q0, input logic [DW-1:0] d0,
                               input bit q1, input logic [DW-1:0] d1, input bit rd);
    rst    = r;
    flush  = f;
    req0   = q0;
    din0   = d0;
    req1   = q1;
    din1   = d1;
    rd_req = rd;
  endtask

  // Compares outputs against the model, then advances both across one edge.
  task automatic checkOutput;
    bit allow, e0, e1, fire;
    int n;
    n     = q.size();
    allow = !rst && !flush && (n < DEPTH);
    e0    = allow && req0 && (!req1 || !m_rr);
    e1    = allow && req1 && (!req0 || m_rr);
    check("gnt0", gnt0, e0);
    check("gnt1", gnt1, e1);
    check("ram_we", ram_we, e0 || e1);
    if (e0 || e1) begin
      check("ram_waddr", ram_waddr, (DEPTH - 1 - wr_idx) % DEPTH);
      check("ram_wdata", ram_wdata, e0 ? din0 : din1);
    end
    check("count", count, n);
    check("full", full, n == DEPTH);
    check("empty", empty, n == 0);
    check("ram_raddr", ram_raddr, (DEPTH - 1 - rd_idx) % DEPTH);
    check("rd_valid", rd_valid, m_valid);
    if (m_valid) check("rd_data", rd_data, m_data);

    fire = rd_req && !flush && (n > 0);
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_rr    = 1'b0;
      wr_idx  = 0;
      rd_idx  = 0;
      m_valid = 1'b0;
    end else if (flush) begin
      q.delete();
      wr_idx  = 0;
      rd_idx  = 0;
      m_valid = 1'b0;
    end else begin
      if (fire) begin
        m_data = q.pop_front();
        rd_idx = (rd_idx + 1) % DEPTH;
      end
      m_valid = fire;
      if (e0) begin
        q.push_back(din0);
        m_rr   = 1'b1;
        wr_idx = (wr_idx + 1) % DEPTH;
      end
      if (e1) begin
        q.push_back(din1);
        m_rr   = 1'b0;
        wr_idx = (wr_idx + 1) % DEPTH;
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc(input bit r, input bit f, input bit q0, input logic [DW-1:0] d0,
                     input bit q1, input logic [DW-1:0] d1, input bit rd);
    applyStimulus(r, f, q0, d0, q1, d1, rd);
    #1;
    checkOutput();
  endtask

  task automatic doReset;
    cyc(1, 1, 1, 16'hDEAD, 1, 16'hBEEF, 1);
    cyc(1, 0, 1, 16'h1234, 0, 16'h0, 1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_rr        = 1'b0;
    wr_idx      = 0;
    rd_idx      = 0;
    m_valid     = 1'b0;
    m_data      = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    applyStimulus(1, 0, 0, '0, 0, '0, 0);
    @(negedge clk);
    doReset();

    // Single write from requester 0 lands at the top address.
    cyc(0, 0, 1, 16'h1111, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 0, 16'h0, 0);

    // Both requesting from reset alternate 0,1,0,1, then fill and read while full.
    doReset();
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 16'(16'h0A00 + i), 1, 16'(16'h0B00 + i), 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 16'($urandom), 1, 16'($urandom), 0);
    cyc(0, 0, 0, 16'h0, 1, 16'hCAFE, 1);
    cyc(0, 0, 0, 16'h0, 0, 16'h0, 0);

    // No fall-through: a read in the writing cycle is ignored.
    doReset();
    cyc(0, 0, 1, 16'hA5A5, 0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 0, 16'h0, 0);

    // Seventeen write/read pairs drive both pointers through the wrap.
    doReset();
    cyc(0, 0, 0, 16'h0, 1, 16'h5000, 0);
    for (int i = 1; i < 17; i++) cyc(0, 0, 0, 16'h0, 1, 16'(16'h5000 + i), 1);
    cyc(0, 0, 0, 16'h0, 0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 0, 16'h0, 0);

    // Flush with pending requests blocks grant and read and keeps rr.
    doReset();
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 16'(16'h7000 + i), 0, 16'h0, 0);
    cyc(0, 1, 1, 16'h7777, 0, 16'h0, 1);
    cyc(0, 0, 1, 16'h7100, 1, 16'h7200, 0);
    cyc(0, 0, 1, 16'h7101, 1, 16'h7201, 1);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 2) != 0), 16'($urandom),
          ($urandom_range(0, 2) != 0), 16'($urandom),
          ($urandom_range(0, 1) == 0));
    end
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 16'h0, 0, 16'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_arb_ctrl.md
FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

Interface
REQ-001 Parameter DW, default 16, data width in bits.
REQ-002 Parameter AW, default 4, RAM address width; depth is 2**AW (16).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 flush  in  1  synchronous clear of FIFO contents; pointers and count only.
REQ-006 req0  in  1  write request, requester 0.
REQ-007 din0  in  DW  write data, requester 0.
REQ-008 gnt0  out  1  write grant, requester 0; write occurs at this clock edge.
REQ-009 req1  in  1  write request, requester 1.
REQ-010 din1  in  DW  write data, requester 1.
REQ-011 gnt1  out  1  write grant, requester 1.
REQ-012 rd_req  in  1  consumer read request.
REQ-013 rd_data  out  DW  read data; valid only while rd_valid=1.
REQ-014 rd_valid  out  1  rd_data valid, one cycle per accepted read.
REQ-015 ram_we  out  1  RAM port A write enable.
REQ-016 ram_waddr  out  AW  RAM port A address.
REQ-017 ram_wdata  out  DW  RAM port A data.
REQ-018 ram_raddr  out  AW  RAM port B address.
REQ-019 ram_rdata  in  DW  RAM port B data; synchronous read, 1-cycle latency.
REQ-020 full  out  1  count == 2**AW.
REQ-021 empty  out  1  count == 0.
REQ-022 count  out  AW+1  occupancy, 0..16.

Function
REQ-023 Grants are combinational from req0/req1, rr, full and flush; at most one grant per cycle.
REQ-024 No grant while full=1 or flush=1, even if a read is accepted the same cycle.
REQ-025 Both requesting: grant goes to the requester selected by rr; one requesting: that requester is granted regardless of rr.
REQ-026 After any grant to requester i, rr is set to select the other requester on the next edge; rr is unchanged when there is no grant.
REQ-027 ram_we = gnt0|gnt1; ram_wdata = din of the granted requester; ram_waddr = wptr.
REQ-028 wptr decrements by 1 on each write and wraps from 0 to 2**AW-1 (modulo 2**AW).
REQ-029 A read is accepted (rd_fire) when rd_req=1, empty=0 and flush=0.
REQ-030 ram_raddr = rptr combinationally; rptr decrements by 1 on rd_fire with the same wrap rule.
REQ-031 rd_valid is a register set to rd_fire; rd_data = ram_rdata (passthrough); read latency is 1 cycle from rd_fire.
REQ-032 No fall-through: a write to an empty FIFO is not readable until the following cycle.
REQ-033 Simultaneous write and rd_fire: count unchanged; both pointers decrement.
REQ-034 count increments on write only, decrements on rd_fire only; full/empty derive from the registered count.
REQ-035 flush=1: wptr and rptr set to 2**AW-1, count to 0, rd_valid to 0 on the next edge; rr is preserved; RAM contents are left unchanged.

Reset
REQ-036 rst=1 on an edge: wptr=rptr=15, count=0, rr selects requester 0, rd_valid=0; rst overrides flush, req and rd_req.
REQ-037 While rst=1: gnt0=gnt1=ram_we=0; after reset, empty=1, full=0, count=0.
REQ-038 Reset asserted mid-operation discards all stored entries; the first write after reset goes to address 15.

Verification
REQ-039 Reset, then req0 only with din0=0x1111 for 1 cycle -> gnt0=1, ram_waddr=15, ram_we=1; next cycle count=1, empty=0.
REQ-040 req0=req1=1 held for 4 cycles from reset -> grants 0,1,0,1 at addresses 15,14,13,12; count=4.
REQ-041 16 writes, then req1=1 and rd_req=1 with the FIFO full -> gnt1=0, read accepted; next cycle count=15, full=0.
REQ-042 Write 0xA5A5 to an empty FIFO with rd_req=1 the same cycle -> no rd_fire; read next cycle, then rd_valid=1 with rd_data=0xA5A5 one cycle later.
REQ-043 17 write/read pairs from reset -> pointers wrap 0->15; data order preserved; count never exceeds 1.
REQ-044 count=5, flush=1 with req0=1 and rd_req=1 -> no grant, no rd_fire; next cycle count=0, empty=1, rr unchanged.
